// File: rtl/sha256d_core_param.sv
// sha256d_core_param
//   Iterative double-SHA-256 engine for block-header hashing. Starting from a
//   precomputed midstate (chaining value after header bytes 0..63), it compresses
//   the padded 16-byte header tail (pass 1). In double mode it then re-hashes
//   the 256-bit pass-1 digest from the standard IV (pass 2). UNROLL chained rounds
//   are evaluated per clock. The final digest is compared against a target.
//
// Ports
//   CLK             rising-edge clock
//   RST             asynchronous, active-low reset (aborts any job)
//   i_start         request a job; accepted only while o_in_ready=1
//   o_in_ready      engine idle
//   i_mode_double   1: double hash, 0: pass 1 only (latched at accept)
//   i_midstate_in   chaining value, [255:224]=H0 .. [31:0]=H7 (latched)
//   i_tail_in       header bytes 64..79, [127:96]=W0 .. [31:0]=W3 (latched)
//   i_target_in     hit threshold (latched)
//   o_out_valid     result available, held until i_out_ready
//   i_out_ready     consumer accepts result
//   o_digest_mid    pass-1 digest H1
//   o_digest_out    final digest (H2 in double mode, H1 in single mode)
//   o_hit           o_digest_out <= target, unsigned 256-bit compare
module sha256d_core_param #(
    parameter int UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_start,
    output logic         o_in_ready,
    input  logic         i_mode_double,
    input  logic [255:0] i_midstate_in,
    input  logic [127:0] i_tail_in,
    input  logic [255:0] i_target_in,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [255:0] o_digest_mid,
    output logic [255:0] o_digest_out,
    output logic         o_hit
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256d_core_param: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [0:63][31:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] IV_W = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Padding after the 16-byte tail (640-bit message) and after the
    // 32-byte pass-1 digest (256-bit message).
    localparam logic [383:0] PAD1   = {32'h80000000, 320'h0, 32'h00000280};
    localparam logic [255:0] PAD2   = {32'h80000000, 192'h0, 32'h00000100};
    localparam logic [5:0]   T_STEP = 6'(UNROLL);
    localparam logic [5:0]   T_LAST = 6'(64 - UNROLL);

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_RND1,
        S_FIN1,
        S_RND2,
        S_FIN2,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_in_ready;
    logic   w_out_valid;

    logic [0:15][31:0] r_win;      // W[t] .. W[t+15]
    logic [0:7][31:0]  r_st;       // working variables a..h
    logic [0:7][31:0]  r_mid;      // pass-1 chaining value
    logic [255:0]      r_target;
    logic              r_mode;
    logic [5:0]        r_t;
    logic [255:0]      r_digest_mid;
    logic [255:0]      r_digest_out;
    logic              r_hit;

    logic [0:15][31:0] w_win_nxt;
    logic [0:7][31:0]  w_st_nxt;
    logic [0:7][31:0]  w_h1;
    logic [0:7][31:0]  w_h2;

    // Schedule extension: W[t+16+i] for the UNROLL words that slide in this
    // cycle. W[t+14+i] and W[t+9+i] may themselves be words produced earlier in
    // this same cycle once i reaches 2 (resp. 7).
    for (genvar i = 0; i < UNROLL; i++) begin : g_sch
        logic [31:0] w_m2;
        logic [31:0] w_m7;
        logic [31:0] w_new;
        if (i < 2) begin : g_m2_win
            assign w_m2 = r_win[14+i];
        end else begin : g_m2_new
            assign w_m2 = g_sch[i-2].w_new;
        end
        if (i < 7) begin : g_m7_win
            assign w_m7 = r_win[9+i];
        end else begin : g_m7_new
            assign w_m7 = g_sch[i-7].w_new;
        end
        assign w_new = ssig1(w_m2) + w_m7 + ssig0(r_win[1+i]) + r_win[i];
    end

    for (genvar k = 0; k < 16; k++) begin : g_win
        if (k < 16 - UNROLL) begin : g_shift
            assign w_win_nxt[k] = r_win[k+UNROLL];
        end else begin : g_fill
            assign w_win_nxt[k] = g_sch[k-16+UNROLL].w_new;
        end
    end

    // UNROLL chained compression rounds; round j consumes W[t+j] = r_win[j].
    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [0:7][31:0] w_si;
        logic [0:7][31:0] w_so;
        logic [31:0]      w_t1;
        logic [31:0]      w_t2;
        if (j == 0) begin : g_from_reg
            assign w_si = r_st;
        end else begin : g_from_prev
            assign w_si = g_rnd[j-1].w_so;
        end
        assign w_t1 = w_si[7] + bsig1(w_si[4]) + ch(w_si[4], w_si[5], w_si[6])
                    + K_TAB[r_t + 6'(j)] + r_win[j];
        assign w_t2 = bsig0(w_si[0]) + maj(w_si[0], w_si[1], w_si[2]);
        assign w_so = {w_t1 + w_t2, w_si[0], w_si[1], w_si[2],
                       w_si[3] + w_t1, w_si[4], w_si[5], w_si[6]};
    end

    assign w_st_nxt = g_rnd[UNROLL-1].w_so;

    // Feed-forward additions closing each pass.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_h1[k] = r_mid[k] + r_st[k];
            w_h2[k] = IV_W[k] + r_st[k];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (i_start) begin
                    w_state_nxt = S_RND1;
                end
            end
            S_RND1: begin
                if (r_t == T_LAST) begin
                    w_state_nxt = S_FIN1;
                end
            end
            S_FIN1: begin
                w_state_nxt = r_mode ? S_RND2 : S_DONE;
            end
            S_RND2: begin
                if (r_t == T_LAST) begin
                    w_state_nxt = S_FIN2;
                end
            end
            S_FIN2: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_win        <= '0;
            r_st         <= '0;
            r_mid        <= '0;
            r_target     <= '0;
            r_mode       <= 1'b0;
            r_t          <= '0;
            r_digest_mid <= '0;
            r_digest_out <= '0;
            r_hit        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode   <= i_mode_double;
                        r_mid    <= i_midstate_in;
                        r_target <= i_target_in;
                        r_win    <= {i_tail_in, PAD1};
                        r_st     <= i_midstate_in;
                        r_t      <= '0;
                    end
                end
                // r_t wraps to 0 on the last round step.
                S_RND1, S_RND2: begin
                    r_win <= w_win_nxt;
                    r_st  <= w_st_nxt;
                    r_t   <= r_t + T_STEP;
                end
                S_FIN1: begin
                    r_digest_mid <= w_h1;
                    if (r_mode) begin
                        r_win <= {w_h1, PAD2};
                        r_st  <= IV_W;
                        r_t   <= '0;
                    end else begin
                        r_digest_out <= w_h1;
                        r_hit        <= (w_h1 <= r_target);
                    end
                end
                S_FIN2: begin
                    r_digest_out <= w_h2;
                    r_hit        <= (w_h2 <= r_target);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_digest_mid = r_digest_mid;
    assign o_digest_out = r_digest_out;
    assign o_hit        = r_hit;

endmodule

// File: tb/tb_sha256d_core_param.sv
// tb_sha256d_core_param
//   Four engines (UNROLL = 1, 2, 4, 8) share job inputs and out_ready, with a
//   start line each. Expected digests come from a plain FIPS 180-4 compression
//   function operating on whole 512-bit blocks.
`timescale 1ns/1ps
module tb_sha256d_core_param;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] GEN_BLK0 = {32'h01000000, 256'h0,
        32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
        32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
    localparam logic [127:0] GEN_TAIL = 128'h4b1e5e4a29ab5f49ffff001d1dac2b7c;
    localparam logic [255:0] GEN_HASH =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] ONES = '1;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [3:0]   start = '0;
    logic         mode = 1'b0;
    logic [255:0] mid = '0;
    logic [127:0] tail = '0;
    logic [255:0] target = '0;
    logic         out_ready = 1'b0;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [3:0]   hit;
    logic [255:0] dmid [4];
    logic [255:0] dout [4];

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        sha256d_core_param #(.UNROLL(1 << gi)) u_dut (
            .CLK           (CLK),
            .RST           (RST),
            .i_start       (start[gi]),
            .o_in_ready    (in_ready[gi]),
            .i_mode_double (mode),
            .i_midstate_in (mid),
            .i_tail_in     (tail),
            .i_target_in   (target),
            .o_out_valid   (out_valid[gi]),
            .i_out_ready   (out_ready),
            .o_digest_mid  (dmid[gi]),
            .o_digest_out  (dout[gi]),
            .o_hit         (hit[gi])
        );
    end

    int n_chk = 0;
    int n_bad = 0;
    int lat [4];

    typedef struct {
        logic [255:0] m;
        logic [255:0] o;
        logic         h;
    } res_t;
    res_t exp_q [$];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [31:0]  s0;
        logic [31:0]  s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = 32'(blk >> (32 * (15 - i)));
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int k = 0; k < 8; k++) s[k] = 32'(h >> (32 * (7 - k)));
        for (int i = 0; i < 64; i++) begin
            t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[i] + w[i];
            t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
        end
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'(h >> (32 * (7 - k))) + s[k]};
        return r;
    endfunction

    function automatic logic [255:0] model_h1(input logic [255:0] m, input logic [127:0] tl);
        return compress(m, {tl, 32'h80000000, 320'h0, 32'h00000280});
    endfunction

    function automatic logic [255:0] model_h2(input logic [255:0] h1);
        return compress(IV, {h1, 32'h80000000, 192'h0, 32'h00000100});
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Start the same job on all four engines and record each one's
    // accept-to-out_valid latency in edges (-1 if it never arrives).
    task automatic launch_all(input logic md, input logic [255:0] m,
                              input logic [127:0] tl, input logic [255:0] tg);
        bit all_set;
        @(negedge CLK);
        chk("pre_idle", 256'(in_ready), 256'(4'hF));
        mode = md; mid = m; tail = tl; target = tg; start = 4'hF;
        @(posedge CLK);
        #1;
        start = 4'h0;
        for (int i = 0; i < 4; i++) lat[i] = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            all_set = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (lat[i] < 0 && out_valid[i]) lat[i] = c;
                if (lat[i] < 0) all_set = 1'b0;
            end
            if (all_set) break;
        end
    endtask

    task automatic check_all(input string tag, input logic md, input logic [255:0] eh1,
                             input logic [255:0] eout, input logic ehit);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_lat_u%0d", tag, 1 << i), 256'(lat[i]),
                256'(md ? 2 * (64 >> i) + 2 : (64 >> i) + 1));
            chk($sformatf("%s_mid_u%0d", tag, 1 << i), dmid[i], eh1);
            chk($sformatf("%s_out_u%0d", tag, 1 << i), dout[i], eout);
            chk($sformatf("%s_hit_u%0d", tag, 1 << i), 256'(hit[i]), 256'(ehit));
        end
    endtask

    task automatic release_all();
        @(negedge CLK);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("rel_inrdy", 256'(in_ready), 256'(4'hF));
        chk("rel_oval", 256'(out_valid), 256'(4'h0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inrdy"}, 256'(in_ready), 256'(4'hF));
        chk({tag, "_oval"}, 256'(out_valid), 256'(4'h0));
        chk({tag, "_hit"}, 256'(hit), 256'(4'h0));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_mid_u%0d", tag, 1 << i), dmid[i], 256'h0);
            chk($sformatf("%s_out_u%0d", tag, 1 << i), dout[i], 256'h0);
        end
    endtask

    task automatic b2b_drive();
        logic [255:0] m;
        logic [255:0] tg;
        logic [255:0] h1;
        logic [255:0] eo;
        logic [127:0] tl;
        logic         md;
        int           n;
        for (int k = 0; k < 100; k++) begin
            m  = rand256();
            tl = 128'(rand256());
            md = 1'($urandom_range(0, 1));
            h1 = model_h1(m, tl);
            eo = md ? model_h2(h1) : h1;
            case (k % 3)
                0:       tg = eo;
                1:       tg = eo - 256'd1;
                default: tg = rand256();
            endcase
            mode = md; mid = m; tail = tl; target = tg; start[3] = 1'b1;
            n = 0;
            while (!in_ready[3] && n < 100) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 100) chk("b2b_accept_timeout", 256'(n), 256'(0));
            exp_q.push_back('{m: h1, o: eo, h: (eo <= tg)});
            @(posedge CLK);
            @(negedge CLK);
        end
        start[3] = 1'b0;
    endtask

    task automatic b2b_collect();
        int   got;
        res_t e;
        got = 0;
        for (int c = 0; c < 6000 && got < 100; c++) begin
            @(negedge CLK);
            if (out_valid[3]) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_extra_result", 256'(got), 256'(100));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("b2b_mid_%0d", got), dmid[3], e.m);
                    chk($sformatf("b2b_out_%0d", got), dout[3], e.o);
                    chk($sformatf("b2b_hit_%0d", got), 256'(hit[3]), 256'(e.h));
                end
                got++;
            end
        end
        chk("b2b_count", 256'(got), 256'(100));
    endtask

    initial begin
        logic [255:0] gmid;
        logic [255:0] gh1;
        logic [255:0] m;
        logic [255:0] h1;
        logic [255:0] h2;
        logic [127:0] tl;

        gmid = compress(IV, GEN_BLK0);
        gh1  = model_h1(gmid, GEN_TAIL);

        // Power-on reset
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Genesis header, double mode, all four UNROLL values
        launch_all(1'b1, gmid, GEN_TAIL, ONES);
        check_all("gen_dbl", 1'b1, gh1, GEN_HASH, 1'b1);
        release_all();

        // Genesis header, single mode
        launch_all(1'b0, gmid, GEN_TAIL, ONES);
        check_all("gen_sgl", 1'b0, gh1, gh1, 1'b1);
        release_all();

        // Zero target with a 20-cycle stall; start pulses must be ignored
        m  = rand256();
        tl = 128'(rand256());
        h1 = model_h1(m, tl);
        h2 = model_h2(h1);
        launch_all(1'b1, m, tl, 256'h0);
        check_all("tz", 1'b1, h1, h2, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("bp_oval", 256'(out_valid), 256'(4'hF));
            chk("bp_inrdy", 256'(in_ready), 256'(4'h0));
            chk("bp_hit", 256'(hit), 256'(4'h0));
            for (int i = 0; i < 4; i++) chk($sformatf("bp_out_u%0d", 1 << i), dout[i], h2);
            start  = (c % 3 == 0) ? 4'hF : 4'h0;
            mid    = rand256();
            target = ONES;
        end
        start = 4'h0;
        release_all();
        repeat (3) begin
            @(negedge CLK);
            chk("bp_no_queue", 256'(in_ready), 256'(4'hF));
        end

        // Asynchronous reset in the middle of a job
        @(negedge CLK);
        mode = 1'b1; mid = gmid; tail = GEN_TAIL; target = ONES; start = 4'hF;
        @(posedge CLK);
        #1;
        start = 4'h0;
        repeat (30) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        launch_all(1'b1, gmid, GEN_TAIL, ONES);
        check_all("post_rst", 1'b1, gh1, GEN_HASH, 1'b1);
        release_all();

        // Back-to-back random jobs on the UNROLL=8 engine, start held high
        @(negedge CLK);
        out_ready = 1'b1;
        fork
            b2b_drive();
            b2b_collect();
        join
        chk("b2b_queue_empty", 256'(exp_q.size()), 256'(0));
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
